// File: rtl/sub_bytes_seq.sv
// rtl/sub_bytes_seq.sv - multi-cycle AES SubBytes engine, LANES S-box lookups per beat.
// Define SUBBYTES_INV_EN to add the inverse S-box and honour in_inv.
module sub_bytes_seq #(
   parameter int NUM_BYTES = 16,
   parameter int LANES     = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [8*NUM_BYTES-1:0] in_data,
   input  logic                   in_inv,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [8*NUM_BYTES-1:0] out_data,
   output logic                   busy
);
   localparam int BEATS = NUM_BYTES / LANES;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int IW    = $clog2(NUM_BYTES + 1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   localparam logic [0:255][7:0] SBOX_FWD = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

`ifdef SUBBYTES_INV_EN
   localparam logic [0:255][7:0] SBOX_INV = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba7bd62e16914635521c0c7d
   };
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [8*NUM_BYTES-1:0]   data_q, data_d;
`ifdef SUBBYTES_INV_EN
   logic                     inv_q, inv_d;
`else
   logic                     unused_inv;
   assign unused_inv = in_inv;
`endif

   logic [IW-1:0]            lane_idx [LANES];
   logic [7:0]               lane_out [LANES];

   // Each lane picks its byte by comparison so no select can reach past the last byte.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [7:0] lane_in;

      assign lane_idx[l] = IW'(cnt_q) * IW'(LANES) + IW'(l);

      always_comb begin
         lane_in = 8'h00;
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (lane_idx[l] == IW'(i)) begin
               lane_in = data_q[i*8 +: 8];
            end
         end
      end

`ifdef SUBBYTES_INV_EN
      assign lane_out[l] = inv_q ? SBOX_INV[lane_in] : SBOX_FWD[lane_in];
`else
      assign lane_out[l] = SBOX_FWD[lane_in];
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
`ifdef SUBBYTES_INV_EN
      inv_d   = inv_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = BUSY;
               cnt_d   = '0;
               data_d  = in_data;
`ifdef SUBBYTES_INV_EN
               inv_d   = in_inv;
`endif
            end
         end
         BUSY: begin
            for (int i = 0; i < NUM_BYTES; i++) begin
               for (int l = 0; l < LANES; l++) begin
                  if (lane_idx[l] == IW'(i)) begin
                     data_d[i*8 +: 8] = lane_out[l];
                  end
               end
            end
            if (cnt_q == LAST_BEAT) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
`ifdef SUBBYTES_INV_EN
         inv_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
`ifdef SUBBYTES_INV_EN
         inv_q   <= inv_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_data  = data_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// tb/tb_sub_bytes_seq.sv - self-checking bench for sub_bytes_seq
module tb_sub_bytes_seq;
   localparam int NB = 16;
   localparam int W  = 8 * NB;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset, in_valid, in_valid_x, in_inv, out_ready;
   logic [W-1:0] in_data;
   logic         in_ready4, out_valid4, busy4;
   logic         in_ready16, out_valid16, busy16;
   logic         in_ready1, out_valid1, busy1;
   logic [W-1:0] out_data4, out_data16, out_data1;

   sub_bytes_seq #(.NUM_BYTES(NB), .LANES(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
      .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid4),
      .out_ready(out_ready), .out_data(out_data4), .busy(busy4));

   sub_bytes_seq #(.NUM_BYTES(NB), .LANES(16)) dut16 (
      .clk(clk), .reset(reset), .in_valid(in_valid_x), .in_ready(in_ready16),
      .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid16),
      .out_ready(out_ready), .out_data(out_data16), .busy(busy16));

   sub_bytes_seq #(.NUM_BYTES(NB), .LANES(1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid_x), .in_ready(in_ready1),
      .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid1),
      .out_ready(out_ready), .out_data(out_data1), .busy(busy1));

   int checks = 0;
   int errors = 0;
   logic [7:0] fwd_m [256];
   logic [7:0] inv_m [256];

   typedef struct {
      logic [W-1:0] data;
      logic         inv;
      logic [W-1:0] exp;
   } vec_t;
   vec_t vecs [7];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   // GF(2^8) multiplicative inverse followed by the AES affine transform.
   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] b, r, s;
      b = 8'h00;
      for (int c = 1; c < 256; c++)
         if (x != 8'h00 && gmul(x, 8'(c)) == 8'h01) b = 8'(c);
      s = b; r = b;
      for (int k = 0; k < 4; k++) begin
         r = {r[6:0], r[7]};
         s = s ^ r;
      end
      return s ^ 8'h63;
   endfunction

   function automatic logic [W-1:0] model_block(input logic [W-1:0] d, input logic inv);
      logic [W-1:0] r;
      for (int i = 0; i < NB; i++) begin
`ifdef SUBBYTES_INV_EN
         r[i*8 +: 8] = inv ? inv_m[d[i*8 +: 8]] : fwd_m[d[i*8 +: 8]];
`else
         r[i*8 +: 8] = inv ? fwd_m[d[i*8 +: 8]] : fwd_m[d[i*8 +: 8]];
`endif
      end
      return r;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out4(output int n);
      n = 0;
      while (!out_valid4 && n < 100) begin
         tick;
         n++;
      end
   endtask

   // Accept one block on dut4, scramble inputs while busy, stall, then release.
   task automatic run_block(input string name, input logic [W-1:0] d, input logic inv,
                            input logic [W-1:0] exp, input int stall);
      int n;
      in_data = d; in_inv = inv; in_valid = 1'b1; out_ready = 1'b0;
      tick;
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      in_inv   = ~inv;
      wait_out4(n);
      chki({name, " latency"}, n, 4);
      chk({name, " data"}, out_data4, exp);
      repeat (stall) tick;
      if (stall > 0) chk({name, " stalled data"}, out_data4, exp);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk1({name, " released"}, out_valid4, 1'b0);
   endtask

   initial begin
      int n, lat16, lat1;
      logic [W-1:0] seq, seq_exp, d, e;
      logic         inv;

      for (int v = 0; v < 256; v++) fwd_m[v] = sbox_calc(8'(v));
      for (int v = 0; v < 256; v++) inv_m[fwd_m[v]] = 8'(v);

      for (int i = 0; i < NB; i++) seq[i*8 +: 8] = 8'(i);
      seq_exp = 128'h76abd7fe2b670130c56f6bf27b777c63;

      vecs[0] = '{{16{8'h00}}, 1'b0, {16{8'h63}}};
      vecs[1] = '{seq, 1'b0, seq_exp};
      vecs[3] = '{{16{8'h53}}, 1'b0, {16{8'hed}}};
      vecs[5] = '{{16{8'hff}}, 1'b0, {16{8'h16}}};
`ifdef SUBBYTES_INV_EN
      vecs[2] = '{{16{8'h63}}, 1'b1, {16{8'h00}}};
      vecs[4] = '{{16{8'hed}}, 1'b1, {16{8'h53}}};
      vecs[6] = '{{16{8'h16}}, 1'b1, {16{8'hff}}};
`else
      vecs[2] = '{{16{8'h63}}, 1'b1, {16{8'hfb}}};
      vecs[4] = '{{16{8'hed}}, 1'b1, {16{8'h55}}};
      vecs[6] = '{{16{8'h16}}, 1'b1, {16{8'h47}}};
`endif

      reset = 1'b1; in_valid = 1'b0; in_valid_x = 1'b0; in_inv = 1'b0;
      out_ready = 1'b0; in_data = '0;
      tick; tick;
      chk1("reset in_ready", in_ready4, 1'b1);
      chk1("reset out_valid", out_valid4, 1'b0);
      chk1("reset busy", busy4, 1'b0);
      chk("reset out_data", out_data4, '0);
      chk1("reset busy lanes16", busy16, 1'b0);
      chk1("reset busy lanes1", busy1, 1'b0);

      in_valid = 1'b1; in_data = seq;
      tick;
      chk1("reset beats accept busy", busy4, 1'b0);
      chk1("reset beats accept ready", in_ready4, 1'b1);
      reset = 1'b0; in_valid = 1'b0;
      tick;

      for (int k = 0; k < 7; k++)
         run_block($sformatf("vec%0d", k), vecs[k].data, vecs[k].inv, vecs[k].exp, k % 3);

      for (int k = 0; k < 20; k++) begin
         d   = {$urandom, $urandom, $urandom, $urandom};
         inv = 1'($urandom_range(0, 1));
         e   = model_block(d, inv);
         run_block($sformatf("rand%0d", k), d, inv, e, $urandom_range(0, 3));
      end

      // Long stall in DONE with a second block waiting upstream.
      in_data = vecs[0].data; in_inv = 1'b0; in_valid = 1'b1;
      tick;
      in_data = seq;
      wait_out4(n);
      chki("stall latency", n, 4);
      for (int k = 0; k < 10; k++) begin
         tick;
         chk($sformatf("stall data %0d", k), out_data4, vecs[0].exp);
         chk1($sformatf("stall in_ready %0d", k), in_ready4, 1'b0);
         chk1($sformatf("stall out_valid %0d", k), out_valid4, 1'b1);
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk1("stall release out_valid", out_valid4, 1'b0);
      chk1("stall release no accept", busy4, 1'b0);
      tick;
      chk1("stall second accept", busy4, 1'b1);
      in_valid = 1'b0;
      wait_out4(n);
      chki("stall second latency", n, 4);
      chk("stall second data", out_data4, seq_exp);
      out_ready = 1'b1; tick; out_ready = 1'b0;

      // Reset landing on the second BUSY edge discards the block.
      in_data = {$urandom, $urandom, $urandom, $urandom}; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk1("midreset in_ready", in_ready4, 1'b1);
      chk1("midreset out_valid", out_valid4, 1'b0);
      chk("midreset out_data", out_data4, '0);
      run_block("after reset", seq, 1'b0, seq_exp, 1);

      // Single-beat and byte-serial configurations.
      in_data = seq; in_inv = 1'b0; in_valid_x = 1'b1; out_ready = 1'b0;
      tick;
      in_valid_x = 1'b0;
      lat16 = -1; lat1 = -1;
      for (int k = 1; k <= 20; k++) begin
         if (k > 1) tick;
         else #0;
         if (k == 1) tick;
         if (out_valid16 && lat16 < 0) lat16 = k;
         if (out_valid1 && lat1 < 0) lat1 = k;
      end
      chki("lanes16 latency", lat16, 1);
      chki("lanes1 latency", lat1, 16);
      chk("lanes16 data", out_data16, seq_exp);
      chk("lanes1 data", out_data1, seq_exp);
      out_ready = 1'b1; tick; out_ready = 1'b0;
      chk1("lanes16 released", out_valid16, 1'b0);
      chk1("lanes1 released", out_valid1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
